// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the single-clock AXI4-Stream packet FIFO.
// Pointers are compared modulo 2*DEPTH; callers zero-extend them to 32 bits.
package axis_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DROP
  } wr_state_e;

  // Stored entry: {tlast, tuser, tdest, tid, tkeep, tstrb, tdata}
  function automatic int unsigned FIFO_DW(input int unsigned data_w,
                                          input int unsigned id_w,
                                          input int unsigned dest_w,
                                          input int unsigned user_w);
    return data_w + 2 * (data_w / 8) + id_w + dest_w + user_w + 1;
  endfunction

  function automatic bit ptr_full(input logic [31:0] wr,
                                  input logic [31:0] rd,
                                  input int unsigned depth);
    logic [31:0] diff;
    diff = (wr - rd) & (2 * depth - 1);
    return diff == depth;
  endfunction

  function automatic bit ptr_empty(input logic [31:0] wr,
                                   input logic [31:0] rd,
                                   input int unsigned depth);
    logic [31:0] diff;
    diff = (wr - rd) & (2 * depth - 1);
    return diff == 32'd0;
  endfunction

endpackage

// File: rtl/axis_fifo_sync_pkt_if.sv
// AXI4-Stream bundle with master (driver) and slave (receiver) views.
interface axis_fifo_sync_pkt_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned DEST_W = 1,
  parameter int unsigned USER_W = 1
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;
  logic [USER_W-1:0]     tuser;

  modport master (output tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read with read enable.
module axis_fifo_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axis_fifo_sync_pkt.sv
// Single-clock AXIS FIFO: cut-through or store-and-forward with frame rollback.
// The RAM read register is the FWFT output stage; rd_ptr retires on m-side handshake.
module axis_fifo_sync_pkt
  import axis_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH          = 1024,
  parameter  int unsigned DATA_W         = 8,
  parameter  int unsigned ID_W           = 1,
  parameter  int unsigned DEST_W         = 1,
  parameter  int unsigned USER_W         = 1,
  parameter  int unsigned PACKET_MODE    = 0,
  parameter  int unsigned DROP_BAD_FRAME = 0,
  parameter  int unsigned AF_LVL         = DEPTH - 4,
  parameter  int unsigned AE_LVL         = 4,
  localparam int unsigned AW             = $clog2(DEPTH),
  localparam int unsigned PW             = AW + 1
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  axis_fifo_sync_pkt_if.slave   s_axis,
  axis_fifo_sync_pkt_if.master  m_axis,
  output logic [PW-1:0]         fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  drop_pulse,
  output logic                  bad_frame_pulse
);
  localparam int unsigned EW      = FIFO_DW(DATA_W, ID_W, DEST_W, USER_W);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_cur_q, wr_cur_d;
  logic [PW-1:0] wr_cmt_q, wr_cmt_d;
  logic [PW-1:0] fetch_ptr, fill_d;
  logic          tvalid_q, tvalid_d;
  wr_state_e     state_q, state_d;
  logic          drop_q, drop_d, bad_q, bad_d, af_q, ae_q;
  logic          full, rd_empty, s_hs, m_hs, load, mem_we;
  logic [EW-1:0] wdata, rdata;

  assign full      = ptr_full(32'(wr_cur_q), 32'(rd_ptr_q), DEPTH);
  // The beat sitting in the output register has been fetched but not retired
  assign fetch_ptr = rd_ptr_q + PW'(tvalid_q);
  assign rd_empty  = ptr_empty(32'(wr_cmt_q), 32'(fetch_ptr), DEPTH);

  assign s_axis.tready = !axis_rst && ((PACKET_MODE != 0) || !full);
  assign s_hs          = s_axis.tvalid && s_axis.tready;
  assign m_hs          = tvalid_q && m_axis.tready;
  assign load          = !rd_empty && (!tvalid_q || m_axis.tready);

  assign wdata = {s_axis.tlast, s_axis.tuser, s_axis.tdest, s_axis.tid,
                  s_axis.tkeep, s_axis.tstrb, s_axis.tdata};
  assign {m_axis.tlast, m_axis.tuser, m_axis.tdest, m_axis.tid,
          m_axis.tkeep, m_axis.tstrb, m_axis.tdata} = rdata;
  assign m_axis.tvalid = tvalid_q;

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk_i   (axis_clk),
    .we_i    (mem_we),
    .waddr_i (wr_cur_q[AW-1:0]),
    .wdata_i (wdata),
    .re_i    (load),
    .raddr_i (fetch_ptr[AW-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_cur_d = wr_cur_q;
    wr_cmt_d = wr_cmt_q;
    mem_we   = 1'b0;
    drop_d   = 1'b0;
    bad_d    = 1'b0;
    if (PACKET_MODE == 0) begin
      if (s_hs) begin
        mem_we   = 1'b1;
        wr_cur_d = wr_cur_q + PTR_ONE;
      end
      wr_cmt_d = wr_cur_d;
    end else if (s_hs) begin
      case (state_q)
        DROP: begin
          if (s_axis.tlast) begin
            wr_cur_d = wr_cmt_q;
            drop_d   = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          if (full) begin
            // Overflow: discard the whole frame, including a lone tlast beat
            if (s_axis.tlast) begin
              wr_cur_d = wr_cmt_q;
              drop_d   = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = DROP;
            end
          end else begin
            mem_we = 1'b1;
            if (!s_axis.tlast) begin
              wr_cur_d = wr_cur_q + PTR_ONE;
              state_d  = FRAME;
            end else if ((DROP_BAD_FRAME != 0) && s_axis.tuser[0]) begin
              wr_cur_d = wr_cmt_q;
              bad_d    = 1'b1;
              state_d  = IDLE;
            end else begin
              wr_cur_d = wr_cur_q + PTR_ONE;
              wr_cmt_d = wr_cur_q + PTR_ONE;
              state_d  = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    tvalid_d = tvalid_q;
    if (m_hs) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      tvalid_d = 1'b0;
    end
    if (load) tvalid_d = 1'b1;
  end

  assign fill_d = wr_cmt_d - rd_ptr_d;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rd_ptr_q <= '0;
      wr_cur_q <= '0;
      wr_cmt_q <= '0;
      tvalid_q <= 1'b0;
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      bad_q    <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_cur_q <= wr_cur_d;
      wr_cmt_q <= wr_cmt_d;
      tvalid_q <= tvalid_d;
      state_q  <= state_d;
      drop_q   <= drop_d;
      bad_q    <= bad_d;
      af_q     <= 32'(fill_d) >= AF_LVL;
      ae_q     <= 32'(fill_d) <= AE_LVL;
    end
  end

  assign fill_level      = wr_cmt_q - rd_ptr_q;
  assign almost_full     = af_q;
  assign almost_empty    = ae_q;
  assign drop_pulse      = drop_q;
  assign bad_frame_pulse = bad_q;
endmodule

// File: tb/tb_axis_fifo_sync_pkt.sv
// Directed bench: stream instance and packet instance (bad-frame drop enabled), DEPTH=16.
module tb_axis_fifo_sync_pkt;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned DSW   = 4;
  localparam int unsigned UW    = 2;
  localparam int unsigned EW    = 1 + UW + DSW + IW + 2 * (DW / 8) + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  axis_fifo_sync_pkt_if #(.DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW)) s0 ();
  axis_fifo_sync_pkt_if #(.DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW)) m0 ();
  axis_fifo_sync_pkt_if #(.DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW)) s1 ();
  axis_fifo_sync_pkt_if #(.DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW)) m1 ();

  logic [4:0] fill0, fill1;
  logic af0, ae0, dp0, bp0, af1, ae1, dp1, bp1;

  axis_fifo_sync_pkt #(
    .DEPTH(DEPTH), .DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW),
    .PACKET_MODE(0), .DROP_BAD_FRAME(0)
  ) u_str (
    .axis_clk(clk), .axis_rst(rst), .s_axis(s0), .m_axis(m0),
    .fill_level(fill0), .almost_full(af0), .almost_empty(ae0),
    .drop_pulse(dp0), .bad_frame_pulse(bp0)
  );

  axis_fifo_sync_pkt #(
    .DEPTH(DEPTH), .DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW),
    .PACKET_MODE(1), .DROP_BAD_FRAME(1)
  ) u_pkt (
    .axis_clk(clk), .axis_rst(rst), .s_axis(s1), .m_axis(m1),
    .fill_level(fill1), .almost_full(af1), .almost_empty(ae1),
    .drop_pulse(dp1), .bad_frame_pulse(bp1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stream beat i: every sideband field varies with i
  function automatic logic [EW-1:0] sbeat(input int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    return {b[0], b[2:1], b[7:4], b[3:0], ~b[3:0], b[3:0], 32'hC0DE0000 + i};
  endfunction

  function automatic logic [EW-1:0] pbeat(input logic [31:0] d, input logic last, input logic bad);
    return {last, {1'b0, bad}, 4'h3, 4'h2, 4'hF, 4'hF, d};
  endfunction

  function automatic logic [EW-1:0] obs0();
    return {m0.tlast, m0.tuser, m0.tdest, m0.tid, m0.tkeep, m0.tstrb, m0.tdata};
  endfunction

  function automatic logic [EW-1:0] obs1();
    return {m1.tlast, m1.tuser, m1.tdest, m1.tid, m1.tkeep, m1.tstrb, m1.tdata};
  endfunction

  task automatic drv0(input logic v, input logic [EW-1:0] e);
    {s0.tlast, s0.tuser, s0.tdest, s0.tid, s0.tkeep, s0.tstrb, s0.tdata} = e;
    s0.tvalid = v;
  endtask

  task automatic drv1(input logic v, input logic [EW-1:0] e);
    {s1.tlast, s1.tuser, s1.tdest, s1.tid, s1.tkeep, s1.tstrb, s1.tdata} = e;
    s1.tvalid = v;
  endtask

  initial begin
    drv0(1'b0, '0);
    drv1(1'b0, '0);
    m0.tready = 1'b0;
    m1.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_s_tready0", 64'(s0.tready), 64'd0);
    chk("rst_s_tready1", 64'(s1.tready), 64'd0);
    chk("rst_m_tvalid0", 64'(m0.tvalid), 64'd0);
    chk("rst_m_tvalid1", 64'(m1.tvalid), 64'd0);
    chk("rst_fill0", 64'(fill0), 64'd0);
    chk("rst_ae0", 64'(ae0), 64'd1);
    chk("rst_af0", 64'(af0), 64'd0);
    chk("rst_drop1", 64'(dp1), 64'd0);
    chk("rst_bad1", 64'(bp1), 64'd0);
    rst = 1'b0;
    tick;
    chk("post_rst_tready0", 64'(s0.tready), 64'd1);
    chk("post_rst_tready1", 64'(s1.tready), 64'd1);

    // 1. Stream fill to full, then drain
    for (int i = 0; i < 16; i++) begin
      drv0(1'b1, sbeat(i));
      if (i == 15) chk("t1_tready_beat16", 64'(s0.tready), 64'd1);
      tick;
    end
    drv0(1'b0, '0);
    chk("t1_full_tready", 64'(s0.tready), 64'd0);
    chk("t1_full_fill", 64'(fill0), 64'd16);
    chk("t1_full_af", 64'(af0), 64'd1);
    chk("t1_full_ae", 64'(ae0), 64'd0);
    chk("t1_head_valid", 64'(m0.tvalid), 64'd1);
    chk("t1_head_data", 64'(obs0()), 64'(sbeat(0)));
    tick;
    chk("t1_stall_hold", 64'(obs0()), 64'(sbeat(0)));
    m0.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t1_rd_valid", 64'(m0.tvalid), 64'd1);
      chk("t1_rd_data", 64'(obs0()), 64'(sbeat(i)));
      tick;
    end
    chk("t1_drained_valid", 64'(m0.tvalid), 64'd0);
    chk("t1_drained_fill", 64'(fill0), 64'd0);
    chk("t1_drained_ae", 64'(ae0), 64'd1);
    chk("t1_drained_af", 64'(af0), 64'd0);
    chk("t1_drained_tready", 64'(s0.tready), 64'd1);

    // 2. Stream full-rate, 100 beats: two-edge latency then no bubbles
    for (int c = 0; c < 102; c++) begin
      if (c < 100) drv0(1'b1, sbeat(c + 16));
      else drv0(1'b0, '0);
      if (c < 2) begin
        chk("t2_latency", 64'(m0.tvalid), 64'd0);
      end else begin
        chk("t2_valid", 64'(m0.tvalid), 64'd1);
        chk("t2_beat", 64'(obs0()), 64'(sbeat(c - 2 + 16)));
      end
      tick;
    end
    chk("t2_end_valid", 64'(m0.tvalid), 64'd0);
    chk("t2_end_fill", 64'(fill0), 64'd0);

    // 3. Packet: 5-beat frame held until committed
    m1.tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drv1(1'b1, pbeat(32'h100 + k, k == 4, 1'b0));
      chk("t3_hold", 64'(m1.tvalid), 64'd0);
      tick;
    end
    drv1(1'b0, '0);
    chk("t3_commit_edge_valid", 64'(m1.tvalid), 64'd0);
    chk("t3_commit_fill", 64'(fill1), 64'd5);
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("t3_rd_valid", 64'(m1.tvalid), 64'd1);
      chk("t3_rd_data", 64'(obs1()), 64'(pbeat(32'h100 + k, k == 4, 1'b0)));
      tick;
    end
    chk("t3_done_valid", 64'(m1.tvalid), 64'd0);

    // 4. Packet: 20-beat frame overflows and is dropped; next frame passes
    for (int k = 0; k < 20; k++) begin
      drv1(1'b1, pbeat(32'h200 + k, k == 19, 1'b0));
      chk("t4_no_valid", 64'(m1.tvalid), 64'd0);
      if (k == 16) chk("t4_tready_full", 64'(s1.tready), 64'd1);
      tick;
    end
    drv1(1'b0, '0);
    chk("t4_drop_pulse", 64'(dp1), 64'd1);
    chk("t4_no_bad_pulse", 64'(bp1), 64'd0);
    chk("t4_fill", 64'(fill1), 64'd0);
    tick;
    chk("t4_drop_pulse_clr", 64'(dp1), 64'd0);
    chk("t4_still_empty", 64'(m1.tvalid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drv1(1'b1, pbeat(32'h300 + k, k == 2, 1'b0));
      tick;
    end
    drv1(1'b0, '0);
    chk("t4_next_fill", 64'(fill1), 64'd3);
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("t4_next_valid", 64'(m1.tvalid), 64'd1);
      chk("t4_next_data", 64'(obs1()), 64'(pbeat(32'h300 + k, k == 2, 1'b0)));
      tick;
    end
    chk("t4_next_done", 64'(m1.tvalid), 64'd0);

    // 5. Good 2-beat frame followed by a bad 4-beat frame
    m1.tready = 1'b0;
    drv1(1'b1, pbeat(32'h400, 1'b0, 1'b0));
    tick;
    drv1(1'b1, pbeat(32'h401, 1'b1, 1'b0));
    tick;
    for (int k = 0; k < 4; k++) begin
      drv1(1'b1, pbeat(32'h500 + k, k == 3, k == 3));
      tick;
    end
    drv1(1'b0, '0);
    chk("t5_bad_pulse", 64'(bp1), 64'd1);
    chk("t5_no_drop_pulse", 64'(dp1), 64'd0);
    chk("t5_fill", 64'(fill1), 64'd2);
    tick;
    chk("t5_bad_pulse_clr", 64'(bp1), 64'd0);
    m1.tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_good_valid", 64'(m1.tvalid), 64'd1);
      chk("t5_good_data", 64'(obs1()), 64'(pbeat(32'h400 + k, k == 1, 1'b0)));
      tick;
    end
    chk("t5_bad_absent", 64'(m1.tvalid), 64'd0);
    tick;
    chk("t5_bad_absent2", 64'(m1.tvalid), 64'd0);
    chk("t5_fill_end", 64'(fill1), 64'd0);

    // 6. Reset mid-frame on the stream instance, then a clean frame
    m0.tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv0(1'b1, sbeat(600 + k));
      tick;
    end
    drv0(1'b1, sbeat(602));
    chk("t6_pre_valid", 64'(m0.tvalid), 64'd1);
    chk("t6_pre_fill", 64'(fill0), 64'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m0.tvalid), 64'd0);
    chk("t6_rst_fill", 64'(fill0), 64'd0);
    chk("t6_rst_tready", 64'(s0.tready), 64'd0);
    chk("t6_rst_ae", 64'(ae0), 64'd1);
    drv0(1'b0, '0);
    tick;
    rst = 1'b0;
    tick;
    for (int k = 0; k < 3; k++) begin
      drv0(1'b1, sbeat(700 + k));
      tick;
    end
    drv0(1'b0, '0);
    chk("t6_post_fill", 64'(fill0), 64'd3);
    m0.tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_post_valid", 64'(m0.tvalid), 64'd1);
      chk("t6_post_data", 64'(obs0()), 64'(sbeat(700 + k)));
      tick;
    end
    chk("t6_post_done", 64'(m0.tvalid), 64'd0);
    chk("t6_post_fill_end", 64'(fill0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_fifo_sync_pkt.md
Name: axis_fifo_sync_pkt

Overview:
- Single-clock AXI4-Stream FIFO; successor to the async stream FIFO for same-domain buffering.
- Generalised in data, keep, id, dest and user width. Adds a store-and-forward packet mode, rollback-based frame drop on overflow or bad frame, and fill-level/threshold status.
- Sits between AXIS producers and consumers inside one clock domain.

Parameters:
- DEPTH, 1024, entries; power of 2, >= 4
- DATA_W, 8, tdata width; multiple of 8
- ID_W, 1, tid width
- DEST_W, 1, tdest width
- USER_W, 1, tuser width; tuser[0] is the bad-frame flag
- PACKET_MODE, 0, 0 = stream (cut-through), 1 = store-and-forward
- DROP_BAD_FRAME, 0, packet mode only: discard a frame whose tlast beat has tuser[0]=1
- AF_LVL, DEPTH-4, almost_full threshold
- AE_LVL, 4, almost_empty threshold

Ports:
- axis_clk  in  1  sole clock
- axis_rst  in  1  asynchronous reset, active-high
- s_axis_tvalid/tready/tlast  in/out/in  1  slave handshake and frame end
- s_axis_tdata  in  DATA_W  write data
- s_axis_tstrb, s_axis_tkeep  in  DATA_W/8  byte qualifiers
- s_axis_tid/tdest/tuser  in  ID_W/DEST_W/USER_W  sideband
- m_axis_* (same set)  mirrored directions  same widths  master side
- fill_level  out  $clog2(DEPTH)+1  committed beats not yet read
- almost_full  out  1  fill_level >= AF_LVL
- almost_empty  out  1  fill_level <= AE_LVL
- drop_pulse  out  1  one-cycle pulse: frame dropped on overflow
- bad_frame_pulse  out  1  one-cycle pulse: frame dropped as bad

Behaviour:
- Reset (async assert, sync release):
  - All pointers 0; m_axis_tvalid=0; fill_level=0; almost_empty=1; almost_full=0; pulses 0.
  - s_axis_tready=0 while reset is asserted.
  - A partial frame in flight at reset is discarded.
- Entry format: {tlast, tuser, tdest, tid, tkeep, tstrb, tdata}; all fields are carried unmodified.
- Pointers: rd_ptr, wr_ptr_cur, wr_ptr_commit; each $clog2(DEPTH)+1 bits with a wrap MSB.
  - full: wr_ptr_cur and rd_ptr differ in MSB only.
  - empty (reader side): wr_ptr_commit == rd_ptr.
- Stream mode (PACKET_MODE=0):
  - wr_ptr_commit tracks wr_ptr_cur; s_axis_tready = !full.
  - No write while full, even when a read occurs in the same cycle.
- Read side:
  - First-word-fall-through with a registered output stage.
  - A beat accepted at edge N is presented with m_axis_tvalid=1 after edge N+1 (stream mode).
  - Master outputs stay stable while tvalid=1 and tready=0.
  - Sustains 1 beat/cycle with tready held high.
  - Simultaneous read and write when not full: both occur; fill_level is unchanged.
- Packet mode (PACKET_MODE=1):
  - Writes advance wr_ptr_cur only.
  - An accepted tlast beat sets wr_ptr_commit = wr_ptr_cur+1 at the same edge.
  - The first beat of that frame becomes valid on the master side one cycle later.
  - s_axis_tready=1 whenever out of reset.
  - Overflow: if a beat arrives while full mid-frame, enter DROP.
    - In DROP, beats are accepted and discarded through tlast.
    - Then wr_ptr_cur <= wr_ptr_commit and drop_pulse=1 on the tlast edge.
  - Bad frame: tlast beat with tuser[0]=1 and DROP_BAD_FRAME=1 -> wr_ptr_cur <= wr_ptr_commit; bad_frame_pulse=1; no commit.
  - A frame larger than DEPTH is always dropped.
  - Write FSM: IDLE -> (accepted non-tlast beat) FRAME -> (tlast) IDLE; FRAME -> (full) DROP -> (tlast) IDLE.
  - A single-beat frame commits directly from IDLE.
- Wrap-around: all pointer arithmetic is modulo 2*DEPTH; address = pointer[LSBs].
- fill_level = wr_ptr_commit - rd_ptr, counting the beat held in the output register. almost_full and almost_empty are registered.

Decomposition:
- Package axis_fifo_pkg:
  - FIFO_DW(data, id, dest, user) width function
  - ptr_full / ptr_empty functions
  - write FSM state enum {IDLE, FRAME, DROP}
- Sub-module axis_fifo_ram: simple dual-port RAM, single clock, registered read, parameters DEPTH and WIDTH.

Test Plan (DEPTH=16, DATA_W=32):
1. Stream: write 0..15 with m_tready=0 -> tready falls after the 16th beat; fill_level=16; almost_full=1. Then m_tready=1 -> reads 0..15 in order; fill_level returns to 0.
2. Stream, both sides at full rate for 100 beats of incrementing data -> no bubbles after the first-beat latency of 1 cycle; data exact; tkeep/tid/tdest/tuser intact.
3. Packet: 5-beat frame with m_tready=1 -> m_tvalid stays 0 until 1 cycle after the tlast edge, then 5 consecutive beats.
4. Packet: 20-beat frame into the empty FIFO -> drop_pulse on beat 20; m_tvalid never rises; fill_level=0. Next 3-beat frame passes intact.
5. Packet, DROP_BAD_FRAME=1: 4-beat frame with tuser[0]=1 on tlast -> bad_frame_pulse; frame absent at output. Preceding good frame is unaffected.
6. Assert axis_rst mid-frame (beat 3 of 6), then resume -> tvalid=0 immediately and fill_level=0; the post-reset frame is read back cleanly.
